// File: rtl/layer_serializer_pkg.sv
// Shared types and helpers for the layer serializer: FSM state encoding and
// counter sizing.
package layer_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // Ceiling log2 with a floor of 1, so a one-word vector still gets a 1-bit counter.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/layer_serializer_buf.sv
// Parallel-load shift register that releases one WIDTH-bit word per shift,
// lowest-indexed word first.
module layer_serializer_buf
    import layer_serializer_pkg::*;
#(
    parameter int NUM_VALUES = 4,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          shift,
    input  logic [NUM_VALUES*WIDTH-1:0]   d,
    output logic [WIDTH-1:0]              q
);

    logic [NUM_VALUES*WIDTH-1:0] data_q;
    logic [NUM_VALUES*WIDTH-1:0] data_d;

    // Next buffer contents: load wins over shift; a shift moves the next word into the low slot.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end else if (shift) begin
            data_d = data_q >> WIDTH;
        end else begin
            data_d = data_q;
        end
    end

    // Buffer register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q[WIDTH-1:0];

endmodule

// File: rtl/layer_serializer.sv
// Captures a full upstream layer output vector on the rising edge of its
// all-valid condition and replays it one word per cycle to the next layer.
module layer_serializer
    import layer_serializer_pkg::*;
#(
    parameter int NUM_VALUES = 4,
    parameter int WIDTH      = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_VALUES*WIDTH-1:0]   VALUES_IN,
    input  logic [NUM_VALUES-1:0]         VALIDS_IN,
    input  logic                          OVERFLOW_IN,
    input  logic                          READY_IN,
    output logic [WIDTH-1:0]              VALUE_OUT,
    output logic                          VALID_OUT,
    output logic                          LAST_OUT,
    output logic                          OVERFLOW_OUT,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          DROPPED
);

    localparam int            CW       = clog2_min1(NUM_VALUES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_VALUES - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          av_q;
    logic          valid_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;
    logic          dropped_q;
    logic          ovf_q;

    logic          all_valid_s;
    logic          cap_ev_s;
    logic          load_s;
    logic          shift_s;
    logic          last_beat_s;

    assign all_valid_s = &VALIDS_IN;
    assign cap_ev_s    = all_valid_s & ~av_q;

    // Next-state, counter and buffer control; READY_IN is only looked at while ARMED.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        last_beat_s = (state_q == ST_STREAM) && (cnt_q == LAST_CNT);
        case (state_q)
            ST_IDLE: begin
                if (cap_ev_s) begin
                    load_s  = 1'b1;
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (READY_IN) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_STREAM: begin
                shift_s = 1'b1;
                if (last_beat_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_STREAM;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and edge-detector registers; av_q resets high so a
    // vector already all-valid at reset release is not treated as new.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            av_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            av_q    <= all_valid_s;
        end
    end

    // Output flags registered from next-state so they line up with the word in the buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            valid_q   <= (state_d == ST_STREAM);
            last_q    <= (state_d == ST_STREAM) && (cnt_d == LAST_CNT);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= last_beat_s;
            dropped_q <= dropped_q | (cap_ev_s && (state_q != ST_IDLE));
            ovf_q     <= load_s ? OVERFLOW_IN : ovf_q;
        end
    end

    layer_serializer_buf #(
        .NUM_VALUES (NUM_VALUES),
        .WIDTH      (WIDTH)
    ) u_buf (
        .clk   (CLK),
        .rst   (RST),
        .load  (load_s),
        .shift (shift_s),
        .d     (VALUES_IN),
        .q     (VALUE_OUT)
    );

    assign VALID_OUT    = valid_q;
    assign LAST_OUT     = last_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign DROPPED      = dropped_q;
    assign OVERFLOW_OUT = ovf_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: a 4-word instance and a 1-word instance.
module tb_layer_serializer;

    logic        CLK;
    logic        RST;
    logic [31:0] VALUES_IN;
    logic [3:0]  VALIDS_IN;
    logic        OVERFLOW_IN;
    logic        READY_IN;
    logic [7:0]  VALUE_OUT;
    logic        VALID_OUT, LAST_OUT, OVERFLOW_OUT, BUSY, DONE, DROPPED;

    logic [7:0]  values1;
    logic [0:0]  valids1;
    logic        ovf1;
    logic [7:0]  value1;
    logic        valid1, last1, ovf_out1, busy1, done1, dropped1;

    int checks = 0;
    int errors = 0;

    logic [5:0] flags_s;
    logic [5:0] flags1_s;
    assign flags_s  = {VALID_OUT, LAST_OUT, BUSY, DONE, DROPPED, OVERFLOW_OUT};
    assign flags1_s = {valid1, last1, busy1, done1, dropped1, ovf_out1};

    layer_serializer #(.NUM_VALUES(4), .WIDTH(8)) u_dut (
        .CLK(CLK), .RST(RST), .VALUES_IN(VALUES_IN), .VALIDS_IN(VALIDS_IN),
        .OVERFLOW_IN(OVERFLOW_IN), .READY_IN(READY_IN), .VALUE_OUT(VALUE_OUT),
        .VALID_OUT(VALID_OUT), .LAST_OUT(LAST_OUT), .OVERFLOW_OUT(OVERFLOW_OUT),
        .BUSY(BUSY), .DONE(DONE), .DROPPED(DROPPED)
    );

    layer_serializer #(.NUM_VALUES(1), .WIDTH(8)) u_dut1 (
        .CLK(CLK), .RST(RST), .VALUES_IN(values1), .VALIDS_IN(valids1),
        .OVERFLOW_IN(ovf1), .READY_IN(READY_IN), .VALUE_OUT(value1),
        .VALID_OUT(valid1), .LAST_OUT(last1), .OVERFLOW_OUT(ovf_out1),
        .BUSY(busy1), .DONE(done1), .DROPPED(dropped1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Checks the flag vector {valid,last,busy,done,dropped,ovf} and, on beats, the word.
    task automatic beat(input string tag, input logic [5:0] exp_flags, input logic [7:0] exp_val);
        check({tag, "_flags"}, 32'(flags_s), 32'(exp_flags));
        if (exp_flags[5]) check({tag, "_value"}, 32'(VALUE_OUT), 32'(exp_val));
    endtask

    logic [7:0] w [4];

    initial begin
        RST = 1'b1; VALUES_IN = 32'h0; VALIDS_IN = 4'h0; OVERFLOW_IN = 1'b0; READY_IN = 1'b1;
        values1 = 8'h00; valids1 = 1'b0; ovf1 = 1'b0;
        tick(); tick();
        check("reset_flags", 32'(flags_s), 32'd0);
        check("reset_value", 32'(VALUE_OUT), 32'd0);
        check("reset_flags1", 32'(flags1_s), 32'd0);
        RST = 1'b0;
        tick();

        // Basic stream
        VALUES_IN = 32'h44332211; VALIDS_IN = 4'hF;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        tick();
        beat("basic_armed", 6'b001000, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            beat("basic_beat", {1'b1, (i == 3), 4'b1000}, w[i]);
            tick();
        end
        beat("basic_done", 6'b000100, 8'h00);
        tick();
        beat("basic_idle", 6'b000000, 8'h00);

        // Ready stall of 5 cycles, VALUES_IN scrambled during the stall
        VALIDS_IN = 4'h0; tick();
        VALUES_IN = 32'hD4C3B2A1; READY_IN = 1'b0; VALIDS_IN = 4'hF;
        w[0] = 8'hA1; w[1] = 8'hB2; w[2] = 8'hC3; w[3] = 8'hD4;
        tick();
        for (int i = 0; i < 5; i++) begin
            beat("stall_wait", 6'b001000, 8'h00);
            VALUES_IN = 32'h5A5A5A5A + 32'(i);
            tick();
        end
        beat("stall_wait_end", 6'b001000, 8'h00);
        READY_IN = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            beat("stall_beat", {1'b1, (i == 3), 4'b1000}, w[i]);
            tick();
        end
        beat("stall_done", 6'b000100, 8'h00);

        // Drop: second rising edge of all_valid during the stream
        VALIDS_IN = 4'h0; tick();
        VALUES_IN = 32'h04030201; VALIDS_IN = 4'hF;
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; w[3] = 8'h04;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            beat("drop_beat", {1'b1, (i == 3), 2'b10, (i >= 2), 1'b0}, w[i]);
            if (i == 0) VALIDS_IN = 4'h0;
            if (i == 1) VALIDS_IN = 4'hF;
            tick();
        end
        beat("drop_done", 6'b000110, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("drop_no_second", 6'b000010, 8'h00);
        end

        // Reset mid-stream, then overflow + signed data
        VALIDS_IN = 4'h0; tick();
        VALUES_IN = 32'h007FFF80; OVERFLOW_IN = 1'b1; VALIDS_IN = 4'hF;
        tick();
        OVERFLOW_IN = 1'b0;
        beat("rst_armed", 6'b001011, 8'h00);
        tick();
        beat("rst_beat0", 6'b101011, 8'h80);
        tick();
        beat("rst_beat1", 6'b101011, 8'hFF);
        RST = 1'b1;
        tick();
        beat("rst_abort", 6'b000000, 8'h00);
        check("rst_value", 32'(VALUE_OUT), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("rst_no_recapture", 6'b000000, 8'h00);
        end
        VALIDS_IN = 4'h0; tick();
        OVERFLOW_IN = 1'b1; VALIDS_IN = 4'hF;
        w[0] = 8'h80; w[1] = 8'hFF; w[2] = 8'h7F; w[3] = 8'h00;
        tick();
        OVERFLOW_IN = 1'b0;
        beat("ovf_armed", 6'b001001, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            beat("ovf_beat", {1'b1, (i == 3), 4'b1001}, w[i]);
            tick();
        end
        beat("ovf_done", 6'b000101, 8'h00);

        // Single-word instance
        values1 = 8'hA5; valids1 = 1'b1;
        tick();
        check("single_armed", 32'(flags1_s), 32'(6'b001000));
        tick();
        check("single_beat", 32'(flags1_s), 32'(6'b111000));
        check("single_value", 32'(value1), 32'h000000A5);
        tick();
        check("single_done", 32'(flags1_s), 32'(6'b000100));
        tick();
        check("single_idle", 32'(flags1_s), 32'(6'b000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Parallel-to-serial bridge between two fully-connected layers. It captures the complete output vector of one layer, `NUM_VALUES` signed words at once, when every neuron reports valid. It then replays the words one per cycle on a `VALUE`/`VALID` stream toward the next layer's single-word input port, starting only when that layer signals ready. It is the transmitter for the layer input path, so layers can be chained without a host in the loop.

## Interface
Parameters:
- `NUM_VALUES`, default 4: number of words in the captured vector (upstream layer outputs); must be ≥ 1.
- `WIDTH`, default 8: signed word width in bits.

Ports:
- `CLK`  in  1: single clock.
- `RST`  in  1: reset; synchronous, active-high.
- `VALUES_IN`  in  `NUM_VALUES*WIDTH`: upstream vector; word k is `[k*WIDTH +: WIDTH]`.
- `VALIDS_IN`  in  `NUM_VALUES`: per-word valid from the upstream layer.
- `OVERFLOW_IN`  in  1: upstream layer overflow flag.
- `READY_IN`  in  1: downstream layer can accept a new stream.
- `VALUE_OUT`  out  `WIDTH`: current streamed word (signed).
- `VALID_OUT`  out  1: `VALUE_OUT` is valid this cycle.
- `LAST_OUT`  out  1: high with the final word of a stream.
- `OVERFLOW_OUT`  out  1: `OVERFLOW_IN` as sampled at capture, held for the stream.
- `BUSY`  out  1: a vector is held (ARMED or STREAM).
- `DONE`  out  1: one-cycle pulse after the last word.
- `DROPPED`  out  1: sticky; a capture event was lost while busy.

## Operation
- `all_valid = &VALIDS_IN`. A capture event is a rising edge of `all_valid`, detected against a registered copy `av_q`.
- States are IDLE, ARMED and STREAM.
- **IDLE**
  - On a capture event: load `VALUES_IN` into the shift buffer, register `OVERFLOW_IN` into `OVERFLOW_OUT`, then go to ARMED.
- **ARMED**
  - Wait for `READY_IN`=1, then go to STREAM and clear the beat counter.
  - `READY_IN` is sampled only here and is not rechecked mid-stream.
- **STREAM**
  - `VALID_OUT`=1 for exactly `NUM_VALUES` consecutive cycles.
  - `VALUE_OUT` presents word 0 first, then 1, and so on; the buffer shifts right by `WIDTH` each beat.
  - On the beat where counter = `NUM_VALUES-1`: `LAST_OUT`=1, and the next state is IDLE with `DONE`=1 for one cycle.
- **Drop handling**
  - A capture event in ARMED or STREAM is ignored: the buffer is unchanged and `DROPPED` is set.
  - `DROPPED` clears only on `RST`.
- **Capture on the DONE cycle**
  - In the IDLE cycle that carries `DONE`, a capture event is accepted normally.
- **Reset**
  - All outputs are 0 and state is IDLE. The buffer and counter are cleared.
  - `av_q` resets to 1, so a `VALIDS_IN` vector still all-high after reset is not recaptured until it drops and rises again.
- **Reset mid-stream**
  - The stream is aborted: `VALID_OUT`/`LAST_OUT` are 0 in the cycle after `RST` is sampled, and no `DONE` is produced.
- **Arithmetic**
  - Words are passed bit-exact; there is no arithmetic.
  - Counter width is `max(1, clog2(NUM_VALUES))`.
- **`NUM_VALUES`=1**
  - STREAM lasts one cycle, with `VALID_OUT` and `LAST_OUT` high together.

## Timing
- Cycle t: capture event sampled.
- t+1: ARMED, `BUSY`=1.
- If `READY_IN`=1 at t+1: words appear at t+2 … t+1+`NUM_VALUES`.
- `DONE` at t+2+`NUM_VALUES`, with `BUSY`=0 in that cycle.
- Minimum capture-to-first-word latency is 2 cycles. Each cycle `READY_IN` stays low in ARMED adds one cycle.
- All outputs are registered; there is no combinational input-to-output path.
- Throughput is one vector per `NUM_VALUES`+2 cycles when back-to-back.

## Structure
- Shared package `layer_serializer_pkg`:
  - state encoding constants (IDLE/ARMED/STREAM);
  - a `clog2`-with-minimum-1 function for counter sizing.
- Sub-module `layer_serializer_buf`:
  - parallel-load, `WIDTH`-granular right-shift register;
  - ports: `load`, `shift`, `d[NUM_VALUES*WIDTH]`, `q[WIDTH]`.
- The top level holds the edge detector, FSM, counter and flags.

## Test plan
- **Basic stream:** `NUM_VALUES`=4, `WIDTH`=8. Drive `VALUES_IN`={0x44,0x33,0x22,0x11}, `VALIDS_IN` 0→0xF, `READY_IN`=1.
  - Expect `VALUE_OUT` 0x11,0x22,0x33,0x44 on cycles t+2..t+5, `LAST_OUT` only at t+5, `DONE` at t+6.
- **Ready stall:** hold `READY_IN`=0 for 5 cycles after capture.
  - Expect `BUSY`=1 with `VALID_OUT`=0 throughout, then the first word 2 cycles after capture plus 5.
  - `VALUES_IN` changed during the stall does not alter the streamed words.
- **Drop:** a second rising edge of `all_valid` during STREAM.
  - Expect the first stream intact and `DROPPED`=1 sticky.
  - Expect no second stream.
- **Reset mid-stream:** `RST` after word 1.
  - Expect `VALID_OUT`=0 the next cycle, no `DONE`, all flags 0.
  - With `VALIDS_IN` held at 0xF, expect no capture until it toggles low then high.
- **Overflow and signed data:** `OVERFLOW_IN`=1 at capture, then 0 one cycle later; words 0x80,0xFF,0x7F,0x00.
  - Expect `OVERFLOW_OUT`=1 for the whole stream and the words output bit-exact.
- **Single word:** `NUM_VALUES`=1, word 0xA5.
  - Expect one beat with `VALID_OUT`=`LAST_OUT`=1, `DONE` the following cycle.
